// File: rtl/dac_serial_writer.sv
// rtl/dac_serial_writer.sv - serial DAC frame writer
//
// Accepts one 8-bit DAC code per handshake and shifts it out as a 16-bit
// frame {CTRL, data, 4'b0000}, MSB first. SCLK idles low; data changes on
// the falling edge and is sampled by the DAC on the rising edge.
//
// Parameters:
//   CLK_DIV   system clocks per SCLK half-period tick (2..255)
//   CTRL      control nibble sent ahead of the data byte
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   enable     permits acceptance of new words (never aborts a frame)
//   din_valid  din_data holds a word to transmit
//   din_data   DAC code to send
//   din_ready  block can accept a word this cycle
//   dac_cs     DAC chip select, active low, registered
//   dac_sclk   DAC serial clock, registered
//   dac_din    DAC serial data, registered
//   tx_done    one-cycle pulse when a frame has completed

module dac_serial_writer #(
    parameter int unsigned CLK_DIV = 12,
    parameter logic [3:0]  CTRL    = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       din_valid,
    input  logic [7:0] din_data,
    output logic       din_ready,
    output logic       dac_cs,
    output logic       dac_sclk,
    output logic       dac_din,
    output logic       tx_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BIT = 5'd16;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  div_cnt;
    logic        tick;
    logic        accept;
    logic [15:0] frame;
    logic [15:0] frame_nxt;
    logic [4:0]  bit_cnt;
    logic [4:0]  bit_cnt_nxt;
    logic [3:0]  bit_idx;
    logic        cs_nxt;
    logic        sclk_nxt;
    logic        din_nxt;
    logic        done_nxt;
    logic        frame_end;

    assign din_ready = (state == ST_IDLE) && enable && !rst;
    assign accept    = din_valid && din_ready;
    assign tick      = (div_cnt == DIV_LAST);
    // Index of the next bit to present; only used while bit_cnt is 1..15.
    assign bit_idx   = 4'd15 - bit_cnt[3:0];
    // Falling toggle after the sixteenth rising edge closes the frame.
    assign frame_end = tick && dac_sclk && (bit_cnt == LAST_BIT);

    // Free-running half-period divider; restarting it on acceptance makes
    // the first tick land exactly CLK_DIV clocks after the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (accept || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            frame    <= '0;
            bit_cnt  <= '0;
            dac_cs   <= 1'b1;
            dac_sclk <= 1'b0;
            dac_din  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            frame    <= frame_nxt;
            bit_cnt  <= bit_cnt_nxt;
            dac_cs   <= cs_nxt;
            dac_sclk <= sclk_nxt;
            dac_din  <= din_nxt;
            tx_done  <= done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)    state_nxt = ST_SETUP;
            ST_SETUP: if (tick)      state_nxt = ST_SHIFT;
            ST_SHIFT: if (frame_end) state_nxt = ST_HOLD;
            ST_HOLD:  if (tick)      state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        frame_nxt   = frame;
        bit_cnt_nxt = bit_cnt;
        cs_nxt      = dac_cs;
        sclk_nxt    = dac_sclk;
        din_nxt     = dac_din;
        done_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    frame_nxt = {CTRL, din_data, 4'b0000};
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    cs_nxt      = 1'b0;
                    din_nxt     = frame[15];
                    bit_cnt_nxt = '0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    sclk_nxt = !dac_sclk;
                    if (!dac_sclk) begin
                        bit_cnt_nxt = bit_cnt + 5'd1;
                    end else if (bit_cnt != LAST_BIT) begin
                        // Present the next bit a full tick before its rising edge.
                        din_nxt = frame[bit_idx];
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    cs_nxt   = 1'b1;
                    din_nxt  = 1'b0;
                    done_nxt = 1'b1;
                end
            end
            default: begin
                cs_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_dac_serial_writer.sv
// tb/tb_dac_serial_writer.sv - bench for dac_serial_writer

module tb_dac_serial_writer;

    logic       clk = 1'b0;
    logic [1:0] rst = 2'b11;
    logic [1:0] enable = 2'b11;
    logic [1:0] din_valid = 2'b00;
    logic [7:0] din_data [2];
    logic [1:0] din_ready;
    logic [1:0] dac_cs;
    logic [1:0] dac_sclk;
    logic [1:0] dac_din;
    logic [1:0] tx_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model / monitor state, one slot per instance.
    logic        busy [2];
    logic        prev_sclk [2];
    logic        prev_cs [2];
    logic        prev_done [2];
    logic [15:0] exp_frame [2];
    logic [15:0] got [2];
    logic [15:0] last_got [2];
    int          nbits [2];
    int          acc_edge [2];
    int          done_edge [2];
    int          last_evt [2];
    int          cs_rise [2];
    int          rise_cnt [2];
    int          acc_cnt [2];
    int          done_cnt [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_serial_writer #(.CLK_DIV(12), .CTRL(4'h0)) u_dut_a (
        .clk(clk), .rst(rst[0]), .enable(enable[0]), .din_valid(din_valid[0]),
        .din_data(din_data[0]), .din_ready(din_ready[0]), .dac_cs(dac_cs[0]),
        .dac_sclk(dac_sclk[0]), .dac_din(dac_din[0]), .tx_done(tx_done[0])
    );

    dac_serial_writer #(.CLK_DIV(2), .CTRL(4'hB)) u_dut_b (
        .clk(clk), .rst(rst[1]), .enable(enable[1]), .din_valid(din_valid[1]),
        .din_data(din_data[1]), .din_ready(din_ready[1]), .dac_cs(dac_cs[1]),
        .dac_sclk(dac_sclk[1]), .dac_din(dac_din[1]), .tx_done(tx_done[1])
    );

    function automatic int div_of(input int i);
        return (i == 0) ? 12 : 2;
    endfunction

    function automatic logic [3:0] ctrl_of(input int i);
        return (i == 0) ? 4'h0 : 4'hB;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            busy[i] = 1'b0; prev_sclk[i] = 1'b0; prev_cs[i] = 1'b1; prev_done[i] = 1'b0;
            exp_frame[i] = '0; got[i] = '0; last_got[i] = '0; nbits[i] = 0;
            acc_edge[i] = 0; done_edge[i] = 0; last_evt[i] = 0; cs_rise[i] = 0;
            rise_cnt[i] = 0; acc_cnt[i] = 0; done_cnt[i] = 0; din_data[i] = 8'h00;
        end
    end

    // Samples on the falling clock edge; cyc then holds the index of the
    // rising edge that produced the values being observed.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                chk("rst_cs", dac_cs[i], 1);
                chk("rst_sclk", dac_sclk[i], 0);
                chk("rst_din", dac_din[i], 0);
                chk("rst_done", tx_done[i], 0);
                chk("rst_ready", din_ready[i], 0);
                busy[i] = 1'b0;
                nbits[i] = 0;
                cs_rise[i] = cyc;
            end else begin
                if (tx_done[i]) begin
                    chk("done_single", prev_done[i], 0);
                    chk("done_expected", busy[i], 1);
                    chk("done_cs_high", dac_cs[i], 1);
                    if (busy[i]) begin
                        chk("done_latency", cyc - acc_edge[i], 34 * div_of(i));
                        chk("frame_bits", nbits[i], 16);
                        chk("frame_data", got[i], exp_frame[i]);
                    end
                    last_got[i] = got[i];
                    busy[i] = 1'b0;
                    done_edge[i] = cyc;
                    done_cnt[i]++;
                end
                if (!dac_cs[i] && prev_cs[i]) begin
                    chk("cs_busy", busy[i], 1);
                    chk("cs_latency", cyc - acc_edge[i], div_of(i));
                    chk("cs_gap", (cyc - cs_rise[i]) >= div_of(i), 1);
                    last_evt[i] = cyc;
                    nbits[i] = 0;
                    got[i] = '0;
                end
                if (dac_cs[i] && !prev_cs[i]) cs_rise[i] = cyc;
                if (dac_sclk[i] != prev_sclk[i]) begin
                    chk("sclk_phase", cyc - last_evt[i], div_of(i));
                    chk("sclk_cs_low", dac_cs[i], 0);
                    last_evt[i] = cyc;
                    if (dac_sclk[i]) begin
                        got[i] = {got[i][14:0], dac_din[i]};
                        nbits[i]++;
                        rise_cnt[i]++;
                    end
                end
                chk("din_ready", din_ready[i], !busy[i] && enable[i]);
                if (!busy[i] && enable[i] && din_valid[i]) begin
                    busy[i] = 1'b1;
                    acc_edge[i] = cyc + 1;
                    exp_frame[i] = {ctrl_of(i), din_data[i], 4'h0};
                    acc_cnt[i]++;
                end
            end
            prev_sclk[i] = dac_sclk[i];
            prev_cs[i] = dac_cs[i];
            prev_done[i] = tx_done[i];
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns just after the falling-edge monitor has seen the handshake.
    task automatic wait_acc(input int i, input int n0);
        int t = 0;
        while (acc_cnt[i] == n0 && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("acc_timeout", acc_cnt[i] != n0, 1);
    endtask

    task automatic wait_done(input int i, input int n0);
        int t = 0;
        while (done_cnt[i] == n0 && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("done_timeout", done_cnt[i] != n0, 1);
        step(1);
    endtask

    task automatic wait_rises(input int i, input int n);
        int t = 0;
        while (rise_cnt[i] < n && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("rise_timeout", rise_cnt[i] >= n, 1);
    endtask

    task automatic send(input int i, input logic [7:0] d);
        int n0 = acc_cnt[i];
        din_data[i] = d;
        din_valid[i] = 1'b1;
        wait_acc(i, n0);
        step(1);
        din_valid[i] = 1'b0;
    endtask

    task automatic send_wait(input int i, input logic [7:0] d);
        int n0 = done_cnt[i];
        send(i, d);
        wait_done(i, n0);
    endtask

    initial begin
        int n0;
        int r0;
        logic [7:0] d;

        step(4);
        rst = 2'b00;
        step(2);

        // Directed 0xA5 frame.
        send_wait(0, 8'hA5);
        chk("a5_frame", last_got[0], 16'h0A50);

        // Back-to-back 0x00 then 0xFF with din_valid held.
        n0 = acc_cnt[0];
        din_data[0] = 8'h00;
        din_valid[0] = 1'b1;
        wait_acc(0, n0);
        step(1);
        din_data[0] = 8'hFF;
        wait_acc(0, n0 + 1);
        chk("b2b_accept", acc_edge[0] - done_edge[0], 1);
        chk("b2b_first", last_got[0], 16'h0000);
        n0 = done_cnt[0];
        step(1);
        din_valid[0] = 1'b0;
        wait_done(0, n0);
        chk("b2b_second", last_got[0], 16'h0FF0);

        // enable dropped at sclk pulse 5 of a 0x3C frame.
        r0 = rise_cnt[0];
        n0 = done_cnt[0];
        send(0, 8'h3C);
        wait_rises(0, r0 + 5);
        enable[0] = 1'b0;
        wait_done(0, n0);
        chk("en_drop_frame", last_got[0], 16'h03C0);
        step(20);
        chk("en_drop_ready", din_ready[0], 0);
        enable[0] = 1'b1;
        step(2);

        // Reset during shift with bit_cnt at 7, then a clean 0x81 frame.
        r0 = rise_cnt[0];
        n0 = done_cnt[0];
        send(0, 8'hC3);
        wait_rises(0, r0 + 7);
        #2;
        rst[0] = 1'b1;
        #1;
        chk("arst_cs", dac_cs[0], 1);
        chk("arst_sclk", dac_sclk[0], 0);
        chk("arst_din", dac_din[0], 0);
        step(3);
        rst[0] = 1'b0;
        step(30);
        chk("arst_no_done", done_cnt[0], n0);
        send_wait(0, 8'h81);
        chk("post_rst_frame", last_got[0], 16'h0810);

        // din_data toggled every clock after accepting 0x5A.
        n0 = done_cnt[0];
        send(0, 8'h5A);
        for (int k = 0; k < 420 && done_cnt[0] == n0; k++) begin
            din_data[0] = ~din_data[0];
            step(1);
        end
        wait_done(0, n0);
        chk("toggle_frame", last_got[0], 16'h05A0);

        // Randomized frames on both dividers with random gaps and enable drops.
        for (int k = 0; k < 10; k++) begin
            int i;
            i = (k < 3) ? 0 : 1;
            d = 8'($urandom);
            step($urandom_range(0, 4));
            n0 = done_cnt[i];
            send(i, d);
            if ($urandom_range(0, 1) == 1) begin
                enable[i] = 1'b0;
                step($urandom_range(1, 40));
                enable[i] = 1'b1;
            end
            wait_done(i, n0);
            chk("rand_frame", last_got[i], {ctrl_of(i), d, 4'h0});
        end

        step(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #800000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
